// File: rtl/ram_fifo_pkg.sv
// Shared constants, FSM encoding and debug view for the 2-entry RAM-backed FIFO controller.
// The optional misuse flag is controlled by the RAM_FIFO_CTRL_ERR_EN macro in ram_fifo_ctrl.
package ram_fifo_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ST_W   = 1;

    localparam logic [ST_W-1:0] ST_IDLE    = 1'b0;
    localparam logic [ST_W-1:0] ST_RD_WAIT = 1'b1;

    // Snapshot of controller state exposed for checkers.
    typedef struct packed {
        logic [ST_W-1:0]  state;
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] count;
    } dbg_t;

endpackage

// File: rtl/ram_fifo_ptr.sv
// Pointer and occupancy bookkeeping for the FIFO; full/empty derive from count alone.
module ram_fifo_ptr
    import ram_fifo_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;
    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);

endmodule

// File: rtl/ram_fifo_ctrl.sv
// 2-entry FIFO controller driving an external single-port 2x8 RAM, one RAM access per cycle.
// Define RAM_FIFO_CTRL_ERR_EN to build the sticky push-when-full / pop-when-empty flag.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop,
    output logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [DATA_W-1:0] ram_x,
    output logic              ram_rw,
    output logic [PTR_W-1:0]  ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic              ram_clear,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              err,
    output dbg_t              dbg_o
);

    // Handshake: a request is accepted in the cycle where req=1 and its ready=1;
    // ready never depends on the same request, and pop wins over push when both are possible.

    logic [ST_W-1:0]   state_q, state_d;
    logic [PTR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push_acc, pop_acc;

    ram_fifo_ptr u_ptr (
        .clk_i    (clk),
        .rst_i    (clear),
        .push_i   (push_acc),
        .pop_i    (pop_acc),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

    always_comb begin
        push_ready = 1'b0;
        pop_ready  = 1'b0;
        if (!clear && state_q == ST_IDLE) begin
            pop_ready  = !empty;
            push_ready = !full && !(pop && !empty);
        end
    end

    assign push_acc = push && push_ready;
    assign pop_acc  = pop && pop_ready;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_acc) begin
                    state_d   = ST_RD_WAIT;
                    rd_addr_d = rd_ptr;
                end
            end
            ST_RD_WAIT: begin
                state_d     = ST_IDLE;
                pop_data_d  = ram_q;
                pop_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM drive is combinational so clear blanks it immediately.
    always_comb begin
        ram_rw   = 1'b0;
        ram_addr = '0;
        ram_x    = '0;
        if (!clear) begin
            if (push_acc) begin
                ram_rw   = 1'b1;
                ram_addr = wr_ptr;
                ram_x    = push_data;
            end else if (pop_acc) begin
                ram_addr = rd_ptr;
            end else if (state_q == ST_RD_WAIT) begin
                ram_addr = rd_addr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
        end
    end

`ifdef RAM_FIFO_CTRL_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            err_q <= 1'b0;
        end else if ((push && full) || (pop && empty)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign ram_clear = clear;
    assign dbg_o     = '{state: state_q, wr_ptr: wr_ptr, rd_ptr: rd_ptr, count: count};

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural 2x8 RAM and a queue-based FIFO model.
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

`ifdef RAM_FIFO_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear, push, pop;
  logic [7:0] push_data;
  logic       push_ready, pop_ready, pop_valid;
  logic [7:0] pop_data, ram_x, ram_q;
  logic       ram_rw, ram_clear, full, empty, err;
  logic [0:0] ram_addr;
  logic [1:0] count;
  dbg_t       dbg;

  int n_pass = 0;
  int n_total = 0;

  ram_fifo_ctrl dut (
    .clk(clk), .clear(clear), .push(push), .push_data(push_data), .push_ready(push_ready),
    .pop(pop), .pop_ready(pop_ready), .pop_data(pop_data), .pop_valid(pop_valid),
    .ram_x(ram_x), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_q(ram_q), .ram_clear(ram_clear),
    .full(full), .empty(empty), .count(count), .err(err), .dbg_o(dbg)
  );

  // clock / external RAM
  always #5 clk = ~clk;

  logic [7:0] mem [0:1];
  always @(posedge clk) if (ram_rw) mem[ram_addr] <= ram_x;
  assign ram_q = mem[ram_addr];

  // reference model: queue contents, read-in-flight flag, output registers
  logic [7:0] mq[$];
  bit         m_busy, m_valid, m_err;
  logic [7:0] m_data, m_pending;
  int         m_wp, m_rp, m_paddr;
  bit         e_push_rdy, e_pop_rdy, e_push_acc, e_pop_acc;

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_valid = 0; m_err = 0;
    m_data = 8'h00; m_pending = 8'h00;
    m_wp = 0; m_rp = 0; m_paddr = 0;
  endtask

  // driver: called at a falling edge, leaves expected handshake values for this cycle
  task automatic drive(input bit p, input logic [7:0] d, input bit q);
    push = p; push_data = d; pop = q;
    #1;
    e_pop_rdy  = !m_busy && mq.size() > 0;
    e_push_rdy = !m_busy && mq.size() < DEPTH && !(q && mq.size() > 0);
    e_push_acc = p && e_push_rdy;
    e_pop_acc  = q && e_pop_rdy;
  endtask

  task automatic advance();
    @(posedge clk);
    if (ERR_EN && ((push && mq.size() == DEPTH) || (pop && mq.size() == 0))) m_err = 1;
    m_valid = m_busy;
    if (m_busy) m_data = m_pending;
    m_busy = e_pop_acc;
    if (e_pop_acc) begin
      m_pending = mq.pop_front();
      m_paddr = m_rp;
      m_rp = (m_rp + 1) % DEPTH;
    end
    if (e_push_acc) begin
      mq.push_back(push_data);
      m_wp = (m_wp + 1) % DEPTH;
    end
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1; push = 0; pop = 0; push_data = 8'h00;
    #1;
    model_reset();
    @(negedge clk);
    clear = 0;
  endtask

  task automatic test_reset();
    push = 1; push_data = 8'hA5; pop = 1;
    #1;
    n_total++; if (ram_rw !== 1'b0) $display("FAIL reset_ram_rw got=%b exp=0", ram_rw); else n_pass++;
    n_total++; if (ram_x !== 8'h00) $display("FAIL reset_ram_x got=%h exp=00", ram_x); else n_pass++;
    n_total++; if (ram_addr !== 1'b0) $display("FAIL reset_ram_addr got=%b exp=0", ram_addr); else n_pass++;
    n_total++; if (ram_clear !== 1'b1) $display("FAIL reset_ram_clear got=%b exp=1", ram_clear); else n_pass++;
    n_total++; if (count !== 2'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags got e=%b f=%b exp e=1 f=0", empty, full); else n_pass++;
    n_total++; if (pop_valid !== 1'b0 || pop_data !== 8'h00) $display("FAIL reset_pop got v=%b d=%h exp v=0 d=00", pop_valid, pop_data); else n_pass++;
    n_total++; if (push_ready !== 1'b0 || pop_ready !== 1'b0) $display("FAIL reset_ready got %b%b exp 00", push_ready, pop_ready); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
    do_clear();
    #1;
    n_total++; if (ram_clear !== 1'b0) $display("FAIL reset_ram_clear_release got=%b exp=0", ram_clear); else n_pass++;
  endtask

  task automatic test_first_push();
    drive(1, 8'hDA, 0);
    n_total++; if (push_ready !== 1'b1) $display("FAIL first_push_ready got=%b exp=1", push_ready); else n_pass++;
    n_total++; if (ram_rw !== 1'b1 || ram_addr !== 1'b0 || ram_x !== 8'hDA)
      $display("FAIL first_push_ram got rw=%b a=%b x=%h exp rw=1 a=0 x=da", ram_rw, ram_addr, ram_x); else n_pass++;
    advance();
    drive(0, 8'h00, 0);
    n_total++; if (count !== 2'd1 || empty !== 1'b0) $display("FAIL first_push_count got c=%0d e=%b exp c=1 e=0", count, empty); else n_pass++;
    n_total++; if (ram_rw !== 1'b0 || ram_x !== 8'h00) $display("FAIL idle_ram got rw=%b x=%h exp rw=0 x=00", ram_rw, ram_x); else n_pass++;
    advance();
  endtask

  task automatic test_fill_drain();
    do_clear();
    drive(1, 8'hDA, 0); advance();
    drive(1, 8'h3C, 0);
    n_total++; if (ram_addr !== 1'b1) $display("FAIL fill_2nd_addr got=%b exp=1", ram_addr); else n_pass++;
    advance();
    drive(0, 8'h00, 1);
    n_total++; if (full !== 1'b1 || count !== 2'd2) $display("FAIL fill_full got f=%b c=%0d exp f=1 c=2", full, count); else n_pass++;
    n_total++; if (push_ready !== 1'b0 || pop_ready !== 1'b1) $display("FAIL fill_ready got %b%b exp 01", push_ready, pop_ready); else n_pass++;
    advance();
    drive(0, 8'h00, 1);
    n_total++; if (pop_ready !== 1'b0 || ram_rw !== 1'b0 || ram_addr !== 1'b0)
      $display("FAIL drain_rdwait got pr=%b rw=%b a=%b exp pr=0 rw=0 a=0", pop_ready, ram_rw, ram_addr); else n_pass++;
    n_total++; if (pop_valid !== 1'b0) $display("FAIL drain_early_valid got=%b exp=0", pop_valid); else n_pass++;
    advance();
    drive(0, 8'h00, 1);
    n_total++; if (pop_valid !== 1'b1 || pop_data !== 8'hDA) $display("FAIL drain_first got v=%b d=%h exp v=1 d=da", pop_valid, pop_data); else n_pass++;
    n_total++; if (pop_ready !== 1'b1 || ram_addr !== 1'b1) $display("FAIL drain_2nd_pop got pr=%b a=%b exp pr=1 a=1", pop_ready, ram_addr); else n_pass++;
    advance();
    drive(0, 8'h00, 0);
    n_total++; if (pop_valid !== 1'b0 || pop_data !== 8'hDA) $display("FAIL drain_hold got v=%b d=%h exp v=0 d=da", pop_valid, pop_data); else n_pass++;
    advance();
    drive(0, 8'h00, 0);
    n_total++; if (pop_valid !== 1'b1 || pop_data !== 8'h3C) $display("FAIL drain_second got v=%b d=%h exp v=1 d=3c", pop_valid, pop_data); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", empty); else n_pass++;
    advance();
  endtask

  task automatic test_push_pop_collision();
    do_clear();
    drive(1, 8'h55, 0); advance();
    drive(1, 8'hAA, 1);
    n_total++; if (push_ready !== 1'b0 || pop_ready !== 1'b1) $display("FAIL collide_ready got %b%b exp 01", push_ready, pop_ready); else n_pass++;
    n_total++; if (ram_rw !== 1'b0 || ram_x !== 8'h00) $display("FAIL collide_ram got rw=%b x=%h exp rw=0 x=00", ram_rw, ram_x); else n_pass++;
    advance();
    drive(0, 8'h00, 0);
    n_total++; if (count !== 2'd0) $display("FAIL collide_count got=%0d exp=0", count); else n_pass++;
    advance();
    drive(0, 8'h00, 0);
    n_total++; if (pop_valid !== 1'b1 || pop_data !== 8'h55) $display("FAIL collide_data got v=%b d=%h exp v=1 d=55", pop_valid, pop_data); else n_pass++;
    advance();
  endtask

  task automatic test_overflow();
    do_clear();
    drive(1, 8'h11, 0); advance();
    drive(1, 8'h22, 0); advance();
    drive(1, 8'h01, 0);
    n_total++; if (push_ready !== 1'b0 || ram_rw !== 1'b0) $display("FAIL ovf_ready got pr=%b rw=%b exp 0 0", push_ready, ram_rw); else n_pass++;
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 8'h00, 0);
      n_total++; if (count !== 2'd2) $display("FAIL ovf_count got=%0d exp=2", count); else n_pass++;
      n_total++; if (err !== ERR_EN) $display("FAIL ovf_err_sticky got=%b exp=%b", err, ERR_EN); else n_pass++;
      advance();
    end
    do_clear();
    #1;
    n_total++; if (err !== 1'b0) $display("FAIL ovf_err_clear got=%b exp=0", err); else n_pass++;
    drive(0, 8'h00, 1);
    n_total++; if (pop_ready !== 1'b0) $display("FAIL udf_ready got=%b exp=0", pop_ready); else n_pass++;
    advance();
    drive(0, 8'h00, 0);
    n_total++; if (err !== ERR_EN || count !== 2'd0) $display("FAIL udf_err got e=%b c=%0d exp e=%b c=0", err, count, ERR_EN); else n_pass++;
    advance();
  endtask

  task automatic test_clear_rd_wait();
    do_clear();
    drive(1, 8'h66, 0); advance();
    drive(0, 8'h00, 1); advance();
    drive(0, 8'h00, 0); advance();
    drive(1, 8'h77, 0); advance();
    drive(0, 8'h00, 1); advance();
    drive(0, 8'h00, 0);
    n_total++; if (ram_addr !== 1'b1 || pop_data !== 8'h66) $display("FAIL abort_pre got a=%b d=%h exp a=1 d=66", ram_addr, pop_data); else n_pass++;
    clear = 1;
    #1;
    n_total++; if (ram_addr !== 1'b0 || ram_rw !== 1'b0 || ram_x !== 8'h00)
      $display("FAIL abort_ram got a=%b rw=%b x=%h exp 0 0 00", ram_addr, ram_rw, ram_x); else n_pass++;
    n_total++; if (pop_data !== 8'h00 || pop_valid !== 1'b0 || count !== 2'd0)
      $display("FAIL abort_regs got d=%h v=%b c=%0d exp 00 0 0", pop_data, pop_valid, count); else n_pass++;
    do_clear();
    drive(1, 8'h99, 0);
    n_total++; if (push_ready !== 1'b1 || pop_valid !== 1'b0) $display("FAIL abort_after got pr=%b v=%b exp pr=1 v=0", push_ready, pop_valid); else n_pass++;
    advance();
    drive(0, 8'h00, 0);
    n_total++; if (pop_valid !== 1'b0 || count !== 2'd1) $display("FAIL abort_no_pulse got v=%b c=%0d exp v=0 c=1", pop_valid, count); else n_pass++;
    advance();
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    do_clear();
    for (int k = 0; k < 3; k++) begin
      d = 8'(8'h40 + k * 8'h13);
      drive(1, d, 0);
      n_total++; if (ram_rw !== 1'b1 || ram_addr !== 1'(k)) $display("FAIL wrap_push k=%0d got rw=%b a=%b exp rw=1 a=%0d", k, ram_rw, ram_addr, k % 2); else n_pass++;
      advance();
      drive(0, 8'h00, 1);
      n_total++; if (ram_rw !== 1'b0 || ram_addr !== 1'(k)) $display("FAIL wrap_pop k=%0d got rw=%b a=%b exp rw=0 a=%0d", k, ram_rw, ram_addr, k % 2); else n_pass++;
      advance();
      drive(0, 8'h00, 0); advance();
      drive(0, 8'h00, 0);
      n_total++; if (pop_valid !== 1'b1 || pop_data !== d) $display("FAIL wrap_data k=%0d got v=%b d=%h exp v=1 d=%h", k, pop_valid, pop_data, d); else n_pass++;
      advance();
    end
  endtask

  task automatic test_random();
    bit p, q;
    logic [7:0] d;
    do_clear();
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 9) < 6);
      q = ($urandom_range(0, 9) < 5);
      d = 8'($urandom_range(0, 255));
      drive(p, d, q);
      n_total++; if (push_ready !== e_push_rdy) $display("FAIL rnd_push_ready cyc=%0d got=%b exp=%b", i, push_ready, e_push_rdy); else n_pass++;
      n_total++; if (pop_ready !== e_pop_rdy) $display("FAIL rnd_pop_ready cyc=%0d got=%b exp=%b", i, pop_ready, e_pop_rdy); else n_pass++;
      n_total++; if (count !== 2'(mq.size())) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, mq.size()); else n_pass++;
      n_total++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0))
        $display("FAIL rnd_flags cyc=%0d got f=%b e=%b size=%0d", i, full, empty, mq.size()); else n_pass++;
      n_total++; if (pop_valid !== m_valid) $display("FAIL rnd_pop_valid cyc=%0d got=%b exp=%b", i, pop_valid, m_valid); else n_pass++;
      n_total++; if (pop_data !== m_data) $display("FAIL rnd_pop_data cyc=%0d got=%h exp=%h", i, pop_data, m_data); else n_pass++;
      n_total++; if (err !== m_err) $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, err, m_err); else n_pass++;
      n_total++; if (ram_rw !== e_push_acc) $display("FAIL rnd_ram_rw cyc=%0d got=%b exp=%b", i, ram_rw, e_push_acc); else n_pass++;
      n_total++; if (ram_x !== (e_push_acc ? d : 8'h00)) $display("FAIL rnd_ram_x cyc=%0d got=%h exp=%h", i, ram_x, e_push_acc ? d : 8'h00); else n_pass++;
      if (e_push_acc || e_pop_acc || m_busy) begin
        int ea;
        ea = e_push_acc ? m_wp : (e_pop_acc ? m_rp : m_paddr);
        n_total++; if (ram_addr !== 1'(ea)) $display("FAIL rnd_ram_addr cyc=%0d got=%b exp=%0d", i, ram_addr, ea); else n_pass++;
      end
      advance();
    end
  endtask

  initial begin
    clear = 1; push = 0; pop = 0; push_data = 8'h00;
    model_reset();
    @(negedge clk);
    test_reset();
    test_first_push();
    test_fill_drain();
    test_push_pop_collision();
    test_overflow();
    test_clear_rd_wait();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: clear  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: push  input  1  write request.
REQ-004 SHALL have port: push_data  input  8  word to enqueue.
REQ-005 SHALL have port: push_ready  output  1  push accepted this cycle when push=1.
REQ-006 SHALL have port: pop  input  1  read request.
REQ-007 SHALL have port: pop_ready  output  1  pop accepted this cycle when pop=1.
REQ-008 SHALL have port: pop_data  output  8  dequeued word, registered.
REQ-009 SHALL have port: pop_valid  output  1  one-cycle pulse, pop_data valid.
REQ-010 SHALL have port: ram_x  output  8  data to the 2x8 RAM.
REQ-011 SHALL have port: ram_rw  output  1  RAM readWrite; 1=write, 0=read.
REQ-012 SHALL have port: ram_addr  output  1  RAM address.
REQ-013 SHALL have port: ram_q  input  8  RAM read data.
REQ-014 SHALL have port: ram_clear  output  1  combinational copy of clear.
REQ-015 SHALL have port: full / empty  output  1 each  count==2 / count==0.
REQ-016 SHALL have port: count  output  2  occupancy 0..2.
REQ-017 SHALL have port: err  output  1  sticky misuse flag (see Configuration).

Function
REQ-018 SHALL implement a 2-entry FIFO over an external single-port 2x8 RAM; one RAM operation per cycle.
REQ-019 SHALL use FSM states IDLE, RD_WAIT.
REQ-020 IDLE: pop_ready = !empty; push_ready = !full && !(pop && !empty).
REQ-021 Simultaneous push and pop in IDLE with count>0: pop SHALL win; push not accepted (push_ready=0).
REQ-022 Accepted push: ram_rw=1, ram_addr=wr_ptr, ram_x=push_data in the same cycle; wr_ptr toggles and count increments at the edge.
REQ-023 Accepted pop (cycle N): ram_rw=0, ram_addr=rd_ptr; rd_ptr toggles, count decrements, FSM goes to RD_WAIT at the edge.
REQ-024 RD_WAIT (cycle N+1): ram_rw=0, ram_addr held at the popped address; push_ready=0, pop_ready=0; pop_data<=ram_q at the edge; FSM returns to IDLE.
REQ-025 pop_valid SHALL be 1 only in cycle N+2; pop latency 2 cycles; maximum pop rate 1 per 2 cycles.
REQ-026 When no operation is accepted, ram_rw SHALL be 0 and ram_x SHALL be 0.
REQ-027 Pointers SHALL be 1-bit and wrap 1->0; full/empty SHALL derive from count only.
REQ-028 pop_data SHALL hold its value until the next capture.

Reset
REQ-029 clear=1 SHALL immediately force: state IDLE, wr_ptr=rd_ptr=0, count=0, pop_data=0, pop_valid=0, err=0, ram_rw=0, ram_addr=0, ram_x=0.
REQ-030 clear asserted in RD_WAIT SHALL abort the read; no pop_valid pulse follows.
REQ-031 After clear deasserts, the first rising edge SHALL already accept requests.

Configuration
REQ-032 Macro RAM_FIFO_CTRL_ERR_EN defined: err SHALL set at the edge when push=1 with full=1, or pop=1 with empty=1, and hold until clear.
REQ-033 Macro undefined: err SHALL be constant 0 and no error logic SHALL be built; the port remains.

Structure
REQ-034 Package ram_fifo_pkg SHALL hold DATA_W=8, DEPTH=2, and the FSM state encoding (IDLE=0, RD_WAIT=1).
REQ-035 Sub-module ram_fifo_ptr SHALL own wr_ptr, rd_ptr, count, full and empty; the top SHALL hold the FSM and the RAM drive.

Verification
REQ-036 clear pulse, then push 0xDA -> ram_rw=1, ram_addr=0, ram_x=0xDA that cycle; next cycle count=1, empty=0.
REQ-037 push 0xDA, push 0x3C, then pop twice -> full=1 after the 2nd push; pop_valid pulses carry 0xDA then 0x3C, each 2 cycles after its pop, pops 2 cycles apart.
REQ-038 count=1, push=pop=1 in IDLE -> push_ready=0, pop accepted, count=0, later pop_valid with the stored word.
REQ-039 fill to full, push 0x01 -> push_ready=0, count stays 2, err=1 iff RAM_FIFO_CTRL_ERR_EN, err stays 1 until clear.
REQ-040 pop accepted, clear asserted during RD_WAIT -> all outputs zero at once, no pop_valid, count=0.
REQ-041 three push/pop cycles -> wr_ptr/rd_ptr wrap 1->0 and data order is preserved.
